csr_machine_file: RTL and testbench

Machine/user-mode CSR register file for the RV32 core: the responder side of the core's CSR interface. Serves combinational CSR reads and registered writes for the execute stage. Accumulates FP exception flags. Performs trap-entry and `mret` state updates requested by the reg-write stage, and exports privilege, status, trap vector and `mepc` to the fetch, load/store, pipeline and interrupt controllers.

---
 rtl/csr_machine_file_pkg.sv | 76 +++++++
 rtl/csr_machine_file_counter64.sv | 34 +++
 rtl/csr_machine_file.sv | 232 +++++++++++++++++++++++
 tb/tb_csr_machine_file.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_machine_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : csr_machine_file_pkg
// Description : Shared CSR addresses, mstatus layout, cause codes, privilege.
// Revision    : 1.0 - initial release
// ============================================================================
package csr_machine_file_pkg;

    typedef enum logic [1:0] {
        PRIV_U = 2'b00,
        PRIV_M = 2'b11
    } priv_e;

    typedef struct packed {
        logic [1:0] mpp;
        logic       mpie;
        logic       mie;
    } csr_mstatus_t;

    localparam logic [11:0] c_csr_fflags    = 12'h001;
    localparam logic [11:0] c_csr_frm       = 12'h002;
    localparam logic [11:0] c_csr_fcsr      = 12'h003;
    localparam logic [11:0] c_csr_mstatus   = 12'h300;
    localparam logic [11:0] c_csr_misa      = 12'h301;
    localparam logic [11:0] c_csr_mie       = 12'h304;
    localparam logic [11:0] c_csr_mtvec     = 12'h305;
    localparam logic [11:0] c_csr_mscratch  = 12'h340;
    localparam logic [11:0] c_csr_mepc      = 12'h341;
    localparam logic [11:0] c_csr_mcause    = 12'h342;
    localparam logic [11:0] c_csr_mtval     = 12'h343;
    localparam logic [11:0] c_csr_mip       = 12'h344;
    localparam logic [11:0] c_csr_mcycle    = 12'hB00;
    localparam logic [11:0] c_csr_minstret  = 12'hB02;
    localparam logic [11:0] c_csr_mcycleh   = 12'hB80;
    localparam logic [11:0] c_csr_minstreth = 12'hB82;
    localparam logic [11:0] c_csr_cycle     = 12'hC00;
    localparam logic [11:0] c_csr_instret   = 12'hC02;
    localparam logic [11:0] c_csr_cycleh    = 12'hC80;
    localparam logic [11:0] c_csr_instreth  = 12'hC82;
    localparam logic [11:0] c_csr_mhartid   = 12'hF14;

    localparam logic [31:0] c_misa_value = 32'h4010_0100;
    localparam logic [31:0] c_mie_mask   = 32'h0000_0888;

    localparam logic [4:0] c_cause_fetch_misaligned = 5'd0;
    localparam logic [4:0] c_cause_illegal_insn     = 5'd2;
    localparam logic [4:0] c_cause_breakpoint       = 5'd3;
    localparam logic [4:0] c_cause_ecall_u          = 5'd8;
    localparam logic [4:0] c_cause_ecall_m          = 5'd11;
    localparam logic [4:0] c_irq_software           = 5'd3;
    localparam logic [4:0] c_irq_timer              = 5'd7;
    localparam logic [4:0] c_irq_external           = 5'd11;

    function automatic logic csr_is_mapped(input logic [11:0] addr);
        case (addr)
            c_csr_fflags, c_csr_frm, c_csr_fcsr,
            c_csr_mstatus, c_csr_misa, c_csr_mie, c_csr_mtvec,
            c_csr_mscratch, c_csr_mepc, c_csr_mcause, c_csr_mtval, c_csr_mip,
            c_csr_mcycle, c_csr_minstret, c_csr_mcycleh, c_csr_minstreth,
            c_csr_cycle, c_csr_instret, c_csr_cycleh, c_csr_instreth,
            c_csr_mhartid: return 1'b1;
            default:       return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] mstatus_image(input csr_mstatus_t s);
        logic [31:0] img;
        img        = '0;
        img[12:11] = s.mpp;
        img[7]     = s.mpie;
        img[3]     = s.mie;
        return img;
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_machine_file_counter64.sv
`default_nettype none
// ============================================================================
// Module      : csr_counter64
// Description : 64-bit counter with increment enable and per-half write ports.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_inc,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic [31:0] i_wr_value,
    output logic [63:0] o_count
);

    logic [63:0] r_count;

    // Any half write freezes the whole counter for that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_wr_lo || i_wr_hi) begin
            if (i_wr_lo) r_count[31:0]  <= i_wr_value;
            if (i_wr_hi) r_count[63:32] <= i_wr_value;
        end else if (i_inc) begin
            r_count <= r_count + 64'd1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/csr_machine_file.sv
`default_nettype none
// ============================================================================
// Module      : csr_machine_file
// Description : RV32 machine/user CSR file with trap entry, mret and counters.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_machine_file
    import csr_machine_file_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read_enable,
    input  logic [11:0] read_addr,
    output logic [31:0] read_value,
    output logic        read_illegal,
    input  logic        write_enable,
    input  logic [11:0] write_addr,
    input  logic [31:0] write_value,
    input  logic        write_fflags,
    input  logic [4:0]  write_fflags_value,
    input  logic        retire,
    input  logic        irq_software,
    input  logic        irq_timer,
    input  logic        irq_external,
    input  logic        trap_valid,
    input  logic        trap_interrupt,
    input  logic [4:0]  trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_value,
    input  logic        trap_return,
    output logic [1:0]  privilege,
    output logic [31:0] status,
    output logic [31:0] mie_out,
    output logic [31:0] mip_out,
    output logic [2:0]  frm,
    output logic [31:0] mepc,
    output logic [31:0] trap_vector
);

    priv_e        r_priv;
    csr_mstatus_t r_mstatus;
    logic [4:0]   r_fflags;
    logic [2:0]   r_frm;
    logic [31:0]  r_mie;
    logic [31:0]  r_mip;
    logic [31:0]  r_mtvec;
    logic [31:0]  r_mscratch;
    logic [31:0]  r_mepc;
    logic [31:0]  r_mcause;
    logic [31:0]  r_mtval;

    logic [63:0]  w_cycle;
    logic [63:0]  w_instret;
    logic [1:0]   w_priv;
    logic [31:0]  w_rd_value;
    logic         w_rd_legal;
    logic         w_wr_legal;
    logic         w_wr_ok;
    logic [31:0]  w_mtvec_base;

    assign w_priv = r_priv;

    // ------------------------------------------------------------------
    // Legality
    // ------------------------------------------------------------------
    assign w_rd_legal = csr_is_mapped(read_addr) && (w_priv >= read_addr[9:8]);

    assign w_wr_legal = csr_is_mapped(write_addr)
                     && (w_priv >= write_addr[9:8])
                     && (write_addr[11:10] != 2'b11)
                     && (write_addr != c_csr_misa)
                     && (write_addr != c_csr_mip);

    assign w_wr_ok = write_enable && w_wr_legal;

    logic w_hit_fflags, w_hit_frm, w_hit_fcsr, w_hit_mstatus, w_hit_mie;
    logic w_hit_mtvec, w_hit_mscratch, w_hit_mepc, w_hit_mcause, w_hit_mtval;
    logic w_hit_mcycle, w_hit_mcycleh, w_hit_minstret, w_hit_minstreth;

    assign w_hit_fflags    = w_wr_ok && (write_addr == c_csr_fflags);
    assign w_hit_frm       = w_wr_ok && (write_addr == c_csr_frm);
    assign w_hit_fcsr      = w_wr_ok && (write_addr == c_csr_fcsr);
    assign w_hit_mstatus   = w_wr_ok && (write_addr == c_csr_mstatus);
    assign w_hit_mie       = w_wr_ok && (write_addr == c_csr_mie);
    assign w_hit_mtvec     = w_wr_ok && (write_addr == c_csr_mtvec);
    assign w_hit_mscratch  = w_wr_ok && (write_addr == c_csr_mscratch);
    assign w_hit_mepc      = w_wr_ok && (write_addr == c_csr_mepc);
    assign w_hit_mcause    = w_wr_ok && (write_addr == c_csr_mcause);
    assign w_hit_mtval     = w_wr_ok && (write_addr == c_csr_mtval);
    assign w_hit_mcycle    = w_wr_ok && (write_addr == c_csr_mcycle);
    assign w_hit_mcycleh   = w_wr_ok && (write_addr == c_csr_mcycleh);
    assign w_hit_minstret  = w_wr_ok && (write_addr == c_csr_minstret);
    assign w_hit_minstreth = w_wr_ok && (write_addr == c_csr_minstreth);

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    csr_counter64 u_cycle (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_inc      (1'b1),
        .i_wr_lo    (w_hit_mcycle),
        .i_wr_hi    (w_hit_mcycleh),
        .i_wr_value (write_value),
        .o_count    (w_cycle)
    );

    csr_counter64 u_instret (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_inc      (retire),
        .i_wr_lo    (w_hit_minstret),
        .i_wr_hi    (w_hit_minstreth),
        .i_wr_value (write_value),
        .o_count    (w_instret)
    );

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_priv     <= PRIV_M;
            r_mstatus  <= '0;
            r_fflags   <= '0;
            r_frm      <= '0;
            r_mie      <= '0;
            r_mip      <= '0;
            r_mtvec    <= '0;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mtval    <= '0;
        end else begin
            r_mip <= {20'b0, irq_external, 3'b0, irq_timer, 3'b0, irq_software, 3'b0};

            // An architectural fflags write overrides accrued flags from the FPU.
            if (w_hit_fflags) begin
                r_fflags <= write_value[4:0];
            end else if (w_hit_fcsr) begin
                r_fflags <= write_value[4:0];
            end else if (write_fflags) begin
                r_fflags <= r_fflags | write_fflags_value;
            end

            if (w_hit_frm) begin
                r_frm <= write_value[2:0];
            end else if (w_hit_fcsr) begin
                r_frm <= write_value[7:5];
            end

            if (w_hit_mie)      r_mie      <= write_value & c_mie_mask;
            if (w_hit_mscratch) r_mscratch <= write_value;
            if (w_hit_mtvec) begin
                r_mtvec <= {write_value[31:2],
                            (write_value[1:0] == 2'b01) ? 2'b01 : 2'b00};
            end

            if (trap_valid) begin
                r_mepc   <= {trap_pc[31:2], 2'b00};
                r_mcause <= {trap_interrupt, 26'b0, trap_cause};
                r_mtval  <= trap_value;
            end else begin
                if (w_hit_mepc)   r_mepc   <= {write_value[31:2], 2'b00};
                if (w_hit_mcause) r_mcause <= write_value;
                if (w_hit_mtval)  r_mtval  <= write_value;
            end

            if (trap_valid) begin
                r_mstatus.mpie <= r_mstatus.mie;
                r_mstatus.mie  <= 1'b0;
                r_mstatus.mpp  <= w_priv;
                r_priv         <= PRIV_M;
            end else if (trap_return) begin
                r_priv         <= priv_e'(r_mstatus.mpp);
                r_mstatus.mie  <= r_mstatus.mpie;
                r_mstatus.mpie <= 1'b1;
                r_mstatus.mpp  <= PRIV_U;
            end else if (w_hit_mstatus) begin
                r_mstatus.mie  <= write_value[3];
                r_mstatus.mpie <= write_value[7];
                r_mstatus.mpp  <= (write_value[12:11] == 2'b11) ? 2'b11 : 2'b00;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_value = '0;
        case (read_addr)
            c_csr_fflags:                    w_rd_value = {27'b0, r_fflags};
            c_csr_frm:                       w_rd_value = {29'b0, r_frm};
            c_csr_fcsr:                      w_rd_value = {24'b0, r_frm, r_fflags};
            c_csr_mstatus:                   w_rd_value = mstatus_image(r_mstatus);
            c_csr_misa:                      w_rd_value = c_misa_value;
            c_csr_mie:                       w_rd_value = r_mie;
            c_csr_mtvec:                     w_rd_value = r_mtvec;
            c_csr_mscratch:                  w_rd_value = r_mscratch;
            c_csr_mepc:                      w_rd_value = r_mepc;
            c_csr_mcause:                    w_rd_value = r_mcause;
            c_csr_mtval:                     w_rd_value = r_mtval;
            c_csr_mip:                       w_rd_value = r_mip;
            c_csr_mcycle,    c_csr_cycle:    w_rd_value = w_cycle[31:0];
            c_csr_mcycleh,   c_csr_cycleh:   w_rd_value = w_cycle[63:32];
            c_csr_minstret,  c_csr_instret:  w_rd_value = w_instret[31:0];
            c_csr_minstreth, c_csr_instreth: w_rd_value = w_instret[63:32];
            default:                         w_rd_value = '0;
        endcase
    end

    assign read_illegal = !w_rd_legal;
    assign read_value   = (read_enable && w_rd_legal) ? w_rd_value : 32'h0;

    // ------------------------------------------------------------------
    // Exported state
    // ------------------------------------------------------------------
    assign w_mtvec_base = {r_mtvec[31:2], 2'b00};
    assign trap_vector  = (trap_interrupt && (r_mtvec[1:0] == 2'b01))
                        ? w_mtvec_base + {25'b0, trap_cause, 2'b00}
                        : w_mtvec_base;

    assign privilege = w_priv;
    assign status    = mstatus_image(r_mstatus);
    assign mie_out   = r_mie;
    assign mip_out   = r_mip;
    assign frm       = r_frm;
    assign mepc      = r_mepc;

endmodule
`default_nettype wire

// File: tb/tb_csr_machine_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_machine_file
// Description : Directed scoreboard bench for the machine-mode CSR file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_machine_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        read_enable;
    logic [11:0] read_addr;
    logic [31:0] read_value;
    logic        read_illegal;
    logic        write_enable;
    logic [11:0] write_addr;
    logic [31:0] write_value;
    logic        write_fflags;
    logic [4:0]  write_fflags_value;
    logic        retire;
    logic        irq_software, irq_timer, irq_external;
    logic        trap_valid, trap_interrupt, trap_return;
    logic [4:0]  trap_cause;
    logic [31:0] trap_pc, trap_value;
    logic [1:0]  privilege;
    logic [31:0] status, mie_out, mip_out, mepc, trap_vector;
    logic [2:0]  frm;

    csr_machine_file dut (
        .clk(clk), .rst_n(rst_n),
        .read_enable(read_enable), .read_addr(read_addr),
        .read_value(read_value), .read_illegal(read_illegal),
        .write_enable(write_enable), .write_addr(write_addr), .write_value(write_value),
        .write_fflags(write_fflags), .write_fflags_value(write_fflags_value),
        .retire(retire),
        .irq_software(irq_software), .irq_timer(irq_timer), .irq_external(irq_external),
        .trap_valid(trap_valid), .trap_interrupt(trap_interrupt), .trap_cause(trap_cause),
        .trap_pc(trap_pc), .trap_value(trap_value), .trap_return(trap_return),
        .privilege(privilege), .status(status), .mie_out(mie_out), .mip_out(mip_out),
        .frm(frm), .mepc(mepc), .trap_vector(trap_vector)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_assert = 0;
    int  n_fail   = 0;

    task automatic push_exp(input string tag, input logic [31:0] v);
        sb_t e;
        e.tag = tag;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        sb_t e;
        n_assert++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] addr, output logic [31:0] v, output logic ill);
        read_enable = 1'b1;
        read_addr   = addr;
        #1;
        v   = read_value;
        ill = read_illegal;
        read_enable = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        logic [31:0] v;
        logic        ill;
        push_exp(tag, exp);
        rd(addr, v, ill);
        check(v);
    endtask

    task automatic ill_chk(input string tag, input logic [11:0] addr, input logic exp);
        logic [31:0] v;
        logic        ill;
        push_exp(tag, {31'b0, exp});
        rd(addr, v, ill);
        check({31'b0, ill});
    endtask

    task automatic csr_wr(input logic [11:0] addr, input logic [31:0] v);
        write_enable = 1'b1;
        write_addr   = addr;
        write_value  = v;
        tick();
        write_enable = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        read_enable = 0; read_addr = '0;
        write_enable = 0; write_addr = '0; write_value = '0;
        write_fflags = 0; write_fflags_value = '0; retire = 0;
        irq_software = 0; irq_timer = 0; irq_external = 0;
        trap_valid = 0; trap_interrupt = 0; trap_cause = '0;
        trap_pc = '0; trap_value = '0; trap_return = 0;

        // Reset state
        repeat (3) tick();
        push_exp("reset_priv", 32'd3);    check({30'b0, privilege});
        push_exp("reset_status", 32'h0);  check(status);
        push_exp("reset_mepc", 32'h0);    check(mepc);
        rst_n = 1'b1;
        rd_chk("reset_mstatus_rd", 12'h300, 32'h0);
        rd_chk("mcycle_0", 12'hB00, 32'd0);
        tick(); rd_chk("mcycle_1", 12'hB00, 32'd1);
        tick(); rd_chk("mcycle_2", 12'hB00, 32'd2);
        tick(); rd_chk("mcycle_3", 12'hB00, 32'd3);

        // Interrupt trap with vectored mtvec
        csr_wr(12'h300, 32'h0000_0008);
        csr_wr(12'h305, 32'h8000_0001);
        rd_chk("mtvec_vectored", 12'h305, 32'h8000_0001);
        trap_valid = 1; trap_interrupt = 1; trap_cause = 5'd7;
        trap_pc = 32'h0000_1236; trap_value = 32'h0000_DEAD;
        #1;
        push_exp("trap_vector_irq7", 32'h8000_001C); check(trap_vector);
        tick();
        trap_valid = 0;
        push_exp("trap_mepc", 32'h0000_1234);  check(mepc);
        rd_chk("trap_mcause", 12'h342, 32'h8000_0007);
        rd_chk("trap_mtval", 12'h343, 32'h0000_DEAD);
        push_exp("trap_status", 32'h0000_1880); check(status);
        trap_interrupt = 0; trap_cause = 5'd2;
        #1;
        push_exp("trap_vector_exc", 32'h8000_0000); check(trap_vector);

        // WARL: mtvec mode 2 -> 0, MPP 1 -> U
        csr_wr(12'h305, 32'h0000_1002);
        rd_chk("mtvec_warl", 12'h305, 32'h0000_1000);
        trap_interrupt = 1; trap_cause = 5'd7;
        #1;
        push_exp("trap_vector_direct", 32'h0000_1000); check(trap_vector);
        trap_interrupt = 0;
        csr_wr(12'h300, 32'h0000_0888);
        push_exp("mpp_warl_status", 32'h0000_0088); check(status);

        // mret into U mode
        trap_return = 1;
        tick();
        trap_return = 0;
        push_exp("mret_priv", 32'd0);        check({30'b0, privilege});
        push_exp("mret_status", 32'h0000_0088); check(status);
        ill_chk("u_mstatus_illegal", 12'h300, 1'b1);
        ill_chk("u_cycle_legal", 12'hC00, 1'b0);
        ill_chk("u_fflags_legal", 12'h001, 1'b0);
        csr_wr(12'h340, 32'h0000_0077);       // must be dropped in U mode

        // Exception trap back to M
        trap_valid = 1; trap_interrupt = 0; trap_cause = 5'd2;
        trap_pc = 32'h0000_2002; trap_value = 32'h0;
        tick();
        trap_valid = 0;
        push_exp("exc_priv", 32'd3);          check({30'b0, privilege});
        push_exp("exc_mepc", 32'h0000_2000);  check(mepc);
        push_exp("exc_status", 32'h0000_0080); check(status);
        rd_chk("u_write_dropped", 12'h340, 32'h0);

        // Unrelated write commits alongside a trap
        trap_valid = 1; trap_cause = 5'd4; trap_pc = 32'h0000_2100;
        csr_wr(12'h340, 32'h0000_0055);
        trap_valid = 0;
        rd_chk("mscratch_with_trap", 12'h340, 32'h0000_0055);
        push_exp("trap2_status", 32'h0000_1800); check(status);

        // trap > mret > write on the same fields
        trap_valid = 1; trap_return = 1; trap_cause = 5'd3; trap_pc = 32'h0000_3000;
        csr_wr(12'h341, 32'h0000_0040);
        trap_valid = 0; trap_return = 0;
        push_exp("prio_mepc", 32'h0000_3000); check(mepc);
        push_exp("prio_priv", 32'd3);         check({30'b0, privilege});
        rd_chk("prio_mcause", 12'h342, 32'h0000_0003);

        // 64-bit cycle counter wrap
        csr_wr(12'hB00, 32'hFFFF_FFFF);
        csr_wr(12'hB80, 32'h0000_0000);
        rd_chk("wrap_lo_hold", 12'hB00, 32'hFFFF_FFFF);
        rd_chk("wrap_hi_hold", 12'hB80, 32'h0);
        tick();
        rd_chk("wrap_hi_carry", 12'hB80, 32'h1);
        rd_chk("wrap_lo_zero", 12'hB00, 32'h0);
        tick();
        rd_chk("wrap_cycleh", 12'hC80, 32'h1);
        rd_chk("wrap_cycle", 12'hC00, 32'h1);

        // instret
        csr_wr(12'hB02, 32'd5);
        retire = 1;
        repeat (3) tick();
        retire = 0;
        rd_chk("instret_8", 12'hC02, 32'd8);
        rd_chk("instreth_0", 12'hB82, 32'd0);

        // fflags accrual and CSR-write precedence
        write_fflags = 1; write_fflags_value = 5'h01; tick();
        write_fflags_value = 5'h04; tick();
        write_fflags = 0;
        rd_chk("fflags_accrue", 12'h001, 32'h05);
        rd_chk("fcsr_accrue", 12'h003, 32'h05);
        write_fflags = 1; write_fflags_value = 5'h1F;
        csr_wr(12'h003, 32'h0000_00E0);
        write_fflags = 0;
        push_exp("fcsr_frm_out", 32'd7); check({29'b0, frm});
        rd_chk("fcsr_fflags_cleared", 12'h001, 32'h0);
        rd_chk("frm_rd", 12'h002, 32'd7);

        // Read-only and unmapped addresses, mie mask, mip sampling
        csr_wr(12'h301, 32'h0);
        rd_chk("misa_ro", 12'h301, 32'h4010_0100);
        rd_chk("mhartid", 12'hF14, 32'h0);
        ill_chk("unmapped_illegal", 12'h7C0, 1'b1);
        csr_wr(12'h304, 32'hFFFF_FFFF);
        push_exp("mie_mask", 32'h0000_0888); check(mie_out);
        irq_timer = 1;
        tick();
        push_exp("mip_out_timer", 32'h0000_0080); check(mip_out);
        rd_chk("mip_rd_timer", 12'h344, 32'h0000_0080);

        // Asynchronous reset mid-operation
        #2;
        rst_n = 1'b0;
        #1;
        push_exp("async_reset_mepc", 32'h0); check(mepc);
        push_exp("async_reset_frm", 32'h0);  check({29'b0, frm});
        tick();
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
